// File: rtl/cpu_pc_capture_pkg.sv
// Shared widths and reset defaults for the PC trigger/capture monitor.
package cpu_pc_capture_pkg;

  localparam int DROP_W = 16;

  // Slot reset defaults: disabled, compare value/mask/threshold all zero.
  localparam logic SLOT_EN_RST     = 1'b0;
  localparam int   SLOT_PC_RST     = 0;
  localparam int   SLOT_MASK_RST   = 0;
  localparam int   SLOT_THRESH_RST = 0;

  function automatic int tid_w(input int num_triggers);
    return (num_triggers > 1) ? $clog2(num_triggers) : 1;
  endfunction

  // Record layout, LSB first: pc, clock_count, regs, trig_id.
  function automatic int rec_w(input int pc_w, input int cnt_w, input int num_regs,
                               input int reg_w, input int num_triggers);
    return pc_w + cnt_w + num_regs * reg_w + tid_w(num_triggers);
  endfunction

endpackage

// File: rtl/cpu_pc_capture_fifo.sv
// Show-ahead synchronous FIFO; head data is visible combinationally while valid.
module cpu_pc_capture_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             push_ok, pop_ok;

  assign valid   = (level != '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop & valid;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_pc_capture_monitor.sv
// PC trigger table with mask/Nth-hit qualification feeding a capture FIFO.
module cpu_pc_capture_monitor
  import cpu_pc_capture_pkg::*;
#(
  parameter int NUM_TRIGGERS = 8,
  parameter int PC_WIDTH     = 32,
  parameter int NUM_REGS     = 5,
  parameter int REG_WIDTH    = 32,
  parameter int CNT_WIDTH    = 48,
  parameter int HIT_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 16,
  localparam int IDX_W = tid_w(NUM_TRIGGERS),
  localparam int REC_W = rec_w(PC_WIDTH, CNT_WIDTH, NUM_REGS, REG_WIDTH, NUM_TRIGGERS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          pc_valid,
  input  logic [PC_WIDTH-1:0]           pc,
  input  logic [NUM_REGS*REG_WIDTH-1:0] regs,
  input  logic                          trig_wr,
  input  logic [IDX_W-1:0]              trig_idx,
  input  logic                          trig_en,
  input  logic [PC_WIDTH-1:0]           trig_pc,
  input  logic [PC_WIDTH-1:0]           trig_mask,
  input  logic [HIT_WIDTH-1:0]          trig_thresh,
  output logic                          cap_valid,
  input  logic                          cap_ready,
  output logic [REC_W-1:0]              cap_data,
  output logic [$clog2(FIFO_DEPTH):0]   cap_level,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_count
);

  typedef struct packed {
    logic                 en;
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  mask;
    logic [HIT_WIDTH-1:0] thresh;
  } slot_t;

  localparam slot_t SLOT_RST = '{en:     SLOT_EN_RST,
                                 pc:     PC_WIDTH'(SLOT_PC_RST),
                                 mask:   PC_WIDTH'(SLOT_MASK_RST),
                                 thresh: HIT_WIDTH'(SLOT_THRESH_RST)};

  slot_t                   slot [NUM_TRIGGERS];
  logic [HIT_WIDTH-1:0]    hit  [NUM_TRIGGERS];
  logic [NUM_TRIGGERS-1:0] match, fire;
  logic [IDX_W-1:0]        trig_id;
  logic [CNT_WIDTH-1:0]    clock_count;
  logic                    push, full, pop;
  logic [REC_W-1:0]        rec;

  always_comb begin
    match = '0;
    fire  = '0;
    for (int k = 0; k < NUM_TRIGGERS; k++) begin
      match[k] = enable & pc_valid & slot[k].en & (((pc ^ slot[k].pc) & slot[k].mask) == '0);
      fire[k]  = match[k] & (hit[k] >= slot[k].thresh);
    end
  end

  // Lowest firing slot wins the record.
  always_comb begin
    trig_id = '0;
    for (int k = NUM_TRIGGERS-1; k >= 0; k--)
      if (fire[k]) trig_id = IDX_W'(k);
  end

  // A slot write discards any same-cycle hit increment on that slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TRIGGERS; k++) begin
        slot[k] <= SLOT_RST;
        hit[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_TRIGGERS; k++) begin
        if (trig_wr && trig_idx == IDX_W'(k)) begin
          slot[k] <= '{en: trig_en, pc: trig_pc, mask: trig_mask, thresh: trig_thresh};
          hit[k]  <= '0;
        end else if (match[k] && hit[k] != '1) begin
          hit[k]  <= hit[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clock_count <= '0;
    else        clock_count <= clock_count + 1'b1;
  end

  assign push = |fire;
  assign pop  = cap_valid & cap_ready;
  assign rec  = {trig_id, regs, clock_count, pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  cpu_pc_capture_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rec),
    .full      (full),
    .pop       (pop),
    .valid     (cap_valid),
    .pop_data  (cap_data),
    .level     (cap_level)
  );

endmodule

// File: tb/tb_cpu_pc_capture_monitor.sv
// Directed + random bench for cpu_pc_capture_monitor against a queue-based reference model.
module tb_cpu_pc_capture_monitor;

  localparam int NT = 8, PW = 32, NR = 5, RW = 32, CW = 48, HW = 8, FD = 16;
  localparam int TW    = 3;
  localparam int REC_W = TW + NR*RW + CW + PW;
  localparam int LW    = 5;
  localparam int HMAX  = 255;

  logic clk = 1'b0;
  logic rst_n, enable, pc_valid, trig_wr, trig_en, cap_ready;
  logic [PW-1:0]    pc, trig_pc, trig_mask;
  logic [NR*RW-1:0] regs;
  logic [TW-1:0]    trig_idx;
  logic [HW-1:0]    trig_thresh;
  logic             cap_valid, overflow;
  logic [REC_W-1:0] cap_data;
  logic [LW-1:0]    cap_level;
  logic [15:0]      drop_count;

  always #5 clk = ~clk;

  cpu_pc_capture_monitor dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pc_valid(pc_valid), .pc(pc), .regs(regs),
    .trig_wr(trig_wr), .trig_idx(trig_idx), .trig_en(trig_en), .trig_pc(trig_pc),
    .trig_mask(trig_mask), .trig_thresh(trig_thresh), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .cap_data(cap_data), .cap_level(cap_level),
    .overflow(overflow), .drop_count(drop_count)
  );

  // Reference model state
  bit               m_en   [NT];
  logic [PW-1:0]    m_pc   [NT];
  logic [PW-1:0]    m_mask [NT];
  int               m_thr  [NT];
  int               m_hit  [NT];
  logic [REC_W-1:0] q[$];
  int               m_drop;
  bit               m_ovf;
  longint unsigned  m_cc;
  int total = 0, bad = 0;

  function automatic void model_reset();
    for (int k = 0; k < NT; k++) begin
      m_en[k] = 0; m_pc[k] = '0; m_mask[k] = '0; m_thr[k] = 0; m_hit[k] = 0;
    end
    q.delete();
    m_drop = 0; m_ovf = 0; m_cc = 0;
  endfunction

  // Applies one clock edge worth of behaviour using the currently driven inputs.
  function automatic void model_cycle();
    int win = -1;
    int nh[NT];
    logic [CW-1:0] cc;
    nh = m_hit;
    for (int k = 0; k < NT; k++) begin
      if (enable && pc_valid && m_en[k] && (((pc ^ m_pc[k]) & m_mask[k]) == '0)) begin
        if (win < 0 && m_hit[k] >= m_thr[k]) win = k;
        if (nh[k] < HMAX) nh[k] = nh[k] + 1;
      end
    end
    if (trig_wr) begin
      m_en[trig_idx] = trig_en; m_pc[trig_idx] = trig_pc;
      m_mask[trig_idx] = trig_mask; m_thr[trig_idx] = int'(trig_thresh);
      nh[trig_idx] = 0;
    end
    m_hit = nh;
    if (cap_ready && q.size() > 0) void'(q.pop_front());
    if (win >= 0) begin
      cc = m_cc[CW-1:0];
      if (q.size() < FD) q.push_back({TW'(win), regs, cc, pc});
      else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop = m_drop + 1;
      end
    end
    m_cc = m_cc + 1;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, cap_valid, q.size() > 0);
    check({tag, ".level"}, cap_level, q.size());
    check({tag, ".ovf"},   overflow, m_ovf);
    check({tag, ".drop"},  drop_count, m_drop);
    check({tag, ".data"},  cap_data, (q.size() > 0) ? q[0] : '0);
  endtask

  task automatic step(input string tag);
    model_cycle();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic rand_regs();
    for (int i = 0; i < NR; i++) regs[i*RW +: RW] = $urandom;
  endtask

  task automatic fire_pc(input logic [PW-1:0] p, input string tag);
    pc_valid = 1; pc = p; rand_regs();
    step(tag);
    pc_valid = 0;
  endtask

  task automatic wr_slot(input int idx, input bit en, input logic [PW-1:0] p,
                         input logic [PW-1:0] m, input int thr);
    trig_wr = 1; trig_idx = TW'(idx); trig_en = en; trig_pc = p; trig_mask = m;
    trig_thresh = HW'(thr);
    step("wr");
    trig_wr = 0;
  endtask

  function automatic logic [PW-1:0] pick_pc();
    case ($urandom_range(0, 4))
      0: return 32'h1000;
      1: return 32'h2000 | PW'($urandom_range(0, 255));
      2: return 32'h3000;
      3: return 32'h5000;
      default: return PW'($urandom);
    endcase
  endfunction

  initial begin
    enable = 1; pc_valid = 0; pc = '0; regs = '0; trig_wr = 0; trig_idx = '0; trig_en = 0;
    trig_pc = '0; trig_mask = '0; trig_thresh = '0; cap_ready = 1;
    rst_n = 1; #1 rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1; check_all("reset");
    rst_n = 1;

    // Idle after reset
    repeat (10) step("idle");

    // Exact-PC trigger, 1-cycle latency
    wr_slot(0, 1, 32'h1000, '1, 0);
    fire_pc(32'h1000, "t2");
    check("t2_valid", cap_valid, 1'b1);
    check("t2_pc",    cap_data[PW-1:0], 32'h1000);
    check("t2_id",    cap_data[REC_W-1 -: TW], 3'd0);

    // Masked compare with 3rd-hit threshold
    wr_slot(2, 1, 32'h2000, 32'hFFFF_FF00, 2);
    fire_pc(32'h2010, "t3a");
    check("t3a_none", cap_valid, 1'b0);
    fire_pc(32'h20F0, "t3b");
    check("t3b_none", cap_valid, 1'b0);
    fire_pc(32'h2044, "t3c");
    check("t3c_id", cap_data[REC_W-1 -: TW], 3'd2);
    fire_pc(32'h2000, "t3d");
    check("t3d_id", cap_data[REC_W-1 -: TW], 3'd2);

    // Two slots match: lowest wins, but the loser still counts the hit
    wr_slot(1, 1, 32'h3000, '1, 0);
    wr_slot(3, 1, 32'h3000, '1, 1);
    fire_pc(32'h3000, "t4a");
    check("t4a_id", cap_data[REC_W-1 -: TW], 3'd1);
    wr_slot(1, 0, 32'h3000, '1, 0);
    fire_pc(32'h3000, "t4b");
    check("t4b_id", cap_data[REC_W-1 -: TW], 3'd3);

    // Overflow with backpressure, then full-FIFO pop+push
    repeat (3) step("drain");
    cap_ready = 0;
    for (int i = 0; i < 20; i++) fire_pc(32'h1000, "t5fill");
    check("t5_level", cap_level, 5'd16);
    check("t5_ovf",   overflow, 1'b1);
    check("t5_drop",  drop_count, 16'd4);
    cap_ready = 1;
    for (int i = 0; i < 5; i++) begin
      fire_pc(32'h1000, "t5pp");
      check("t5_level_hold", cap_level, 5'd16);
    end
    repeat (16) step("t5drain");
    check("t5_empty", cap_level, 5'd0);

    // Slot write colliding with a match on that slot
    pc_valid = 1; pc = 32'h1000; rand_regs();
    trig_wr = 1; trig_idx = 3'd0; trig_en = 1; trig_pc = 32'h5000; trig_mask = '1; trig_thresh = 8'd1;
    step("t6wr");
    trig_wr = 0; pc_valid = 0;
    check("t6_id", cap_data[REC_W-1 -: TW], 3'd0);
    check("t6_pc", cap_data[PW-1:0], 32'h1000);
    fire_pc(32'h5000, "t6b");
    check("t6b_none", cap_valid, 1'b0);
    fire_pc(32'h5000, "t6c");
    check("t6c_valid", cap_valid, 1'b1);

    // All-zero mask matches any PC; enable=0 suppresses everything
    wr_slot(4, 1, 32'h0, 32'h0, 0);
    fire_pc(32'hABCD_0123, "mask0");
    check("mask0_id", cap_data[REC_W-1 -: TW], 3'd4);
    enable = 0;
    fire_pc(32'h5000, "dis");
    check("dis_none", cap_valid, 1'b0);
    enable = 1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 15) != 0);
      pc_valid  = $urandom_range(0, 1);
      pc        = pick_pc();
      rand_regs();
      cap_ready = ($urandom_range(0, 3) != 0);
      trig_wr   = ($urandom_range(0, 15) == 0);
      trig_idx  = TW'($urandom_range(0, NT-1));
      trig_en   = $urandom_range(0, 1);
      trig_pc   = pick_pc();
      case ($urandom_range(0, 2))
        0: trig_mask = '1;
        1: trig_mask = 32'hFFFF_FF00;
        default: trig_mask = '0;
      endcase
      trig_thresh = HW'($urandom_range(0, 3));
      step("rand");
    end
    enable = 1; pc_valid = 0; trig_wr = 0; cap_ready = 1;

    // Asynchronous reset mid-burst
    wr_slot(0, 1, 32'h1000, '1, 0);
    cap_ready = 0;
    for (int i = 0; i < 6; i++) fire_pc(32'h1000, "burst");
    #2 rst_n = 0;
    #1;
    check("arst_valid", cap_valid, 1'b0);
    check("arst_level", cap_level, 5'd0);
    check("arst_data",  cap_data, '0);
    check("arst_ovf",   overflow, 1'b0);
    check("arst_drop",  drop_count, 16'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1; cap_ready = 1;
    check_all("post_rst");
    repeat (3) step("post_idle");
    wr_slot(0, 1, 32'h1000, '1, 0);
    fire_pc(32'h1000, "post_cap");
    check("post_cap_valid", cap_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
